// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder and its prescaler.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic logic [31:0] onehot(input logic [4:0] i);
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/scan_decoder_tick_gen.sv
// Parametrised prescaler: counts 0..PRESCALE-1 and flags the terminal count.
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int            CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear or hold in the same cycle swallows the terminal count.
    assign tick = (cnt_q == TC) & ~clr & ~hold;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and prescaled auto-scan modes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int PRESCALE = 50000,
    parameter bit ACT_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] o,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);
    localparam int           N     = 1 << SEL_W;
    localparam logic [N-1:0] O_OFF = {N{ACT_LOW}};

    state_e           st_q, st_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     o_q, o_d;
    logic             wrap_q, wrap_d;
    logic             presc_clr, presc_hold, tick;

    // The prescaler restarts whenever scan is not already running.
    assign presc_hold = ~en;
    assign presc_clr  = en & ((mode == MODE_DIRECT) | (st_q != ST_SCAN));

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .hold  (presc_hold),
        .tick  (tick)
    );

    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (!en) begin
            st_d = ST_OFF;
        end else if (mode == MODE_DIRECT) begin
            st_d  = ST_DIRECT;
            idx_d = sel;
        end else if (st_q != ST_SCAN) begin
            st_d  = ST_SCAN;
            idx_d = sel;
        end else if (tick) begin
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = (idx_q == {SEL_W{1'b1}});
        end
        // XOR with the inactive pattern applies the output polarity.
        o_d = O_OFF;
        if (en) begin
            o_d = N'(onehot(5'(idx_d))) ^ O_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_OFF;
            idx_q  <= '0;
            o_q    <= O_OFF;
            wrap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            o_q    <= o_d;
            wrap_q <= wrap_d;
        end
    end

    assign o    = o_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised one-hot decoder with an auto-scan mode, replacing the fixed combinational 3-to-8 decoder. It drives N = 2^SEL_W select lines, for example digit enables on a multiplexed seven-segment display or LED columns. In direct mode it decodes an external select. In scan mode it steps through all lines at a prescaled rate.

## Interface
Parameters:
- SEL_W, 3, select width; number of output lines N = 2^SEL_W (SEL_W 1..5)
- PRESCALE, 50000, clock cycles per scan step (>= 1)
- ACT_LOW, 0, 1 = outputs active-low (inactive lines driven 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  enable; 0 forces all outputs inactive and freezes counters
- mode  in  1  0 = direct decode of sel, 1 = auto-scan
- sel  in  SEL_W  direct-mode select; seed index on entry to scan
- o  out  N  decoded lines, exactly one active when enabled
- idx  out  SEL_W  index of currently active line
- wrap  out  1  one-cycle pulse when scan index wraps N-1 -> 0

## Operation
- States: OFF (en=0), DIRECT, SCAN. Reset enters OFF.
- Transitions:
  - any state, en=0 -> OFF
  - OFF, en=1 -> DIRECT if mode=0, SCAN if mode=1
  - DIRECT <-> SCAN follows mode while en=1
- OFF: o all inactive, idx holds, prescaler holds, wrap=0.
- DIRECT: idx <= sel every cycle. o <= onehot(sel). Prescaler held at 0.
- SCAN entry (from OFF or DIRECT): idx <= sel, prescaler <= 0. o shows onehot(sel) on the next cycle.
- SCAN steady:
  - prescaler counts 0..PRESCALE-1.
  - At terminal count, idx <= idx+1 mod N and the prescaler returns to 0.
  - wrap=1 for that single cycle when idx goes N-1 -> 0.
- With PRESCALE=1, idx advances every cycle.
- ACT_LOW=1: o is the bitwise inverse of the one-hot pattern. Inactive = all ones.
- Priority for simultaneous events, highest first: rst_n, en=0, mode change, terminal count. A terminal count coinciding with en falling or a mode change is discarded and does not advance idx.
- Only the modulo-N arithmetic on idx wraps. The prescaler is sized to clog2(PRESCALE) bits minimum and never exceeds PRESCALE-1.

## Timing
- Reset values, applied asynchronously at rst_n low:
  - o = all inactive: 0 for ACT_LOW=0, all ones for ACT_LOW=1
  - idx = 0, wrap = 0, prescaler = 0, state OFF
- Reset release is synchronous in effect: the first state change occurs on the first rising edge with rst_n=1.
- All outputs are registered.
- DIRECT latency: sel change -> o/idx update one clock later.
- SCAN: o/idx change exactly PRESCALE cycles apart. wrap asserts in the same cycle that idx shows 0 after N-1.
- en rising -> first active o one cycle later. en falling -> o inactive one cycle later.
- Reset asserted mid-scan: outputs go to reset values immediately. The scan restarts from sel after release.

## Structure
- Shared package scan_decoder_pkg holds:
  - state enum (ST_OFF, ST_DIRECT, ST_SCAN)
  - MODE_DIRECT / MODE_SCAN constants
  - onehot function
- One sub-module, tick_gen, is the natural split. It is the parametrised prescaler with clear and hold inputs and a tick output. It is reused later for debounce and blink blocks.

## Test plan
All scenarios use SEL_W=3, PRESCALE=4, ACT_LOW=0 unless stated.
- Reset: rst_n=0 mid-scan -> o=8'h00, idx=0, wrap=0 immediately, without waiting for a clock edge.
- Direct sweep: en=1, mode=0, sel=0..7 one per cycle -> o=8'h01, 02, 04 … 80, each one cycle after the matching sel; idx matches sel.
- Scan:
  - mode=1, sel=6 -> o=8'h40, then 8'h80 after 4 cycles, then 8'h01 after 4 more.
  - wrap high only in the cycle o first shows 8'h01.
  - Sustained run: exactly one wrap every 32 cycles.
- Enable gating: en=0 during scan, including on a terminal-count cycle -> o=8'h00 next cycle, idx frozen. On en=1, scan resumes re-seeded from sel.
- Mode change collision: mode 1->0 on a terminal-count cycle -> idx=sel next cycle, no advance, no wrap.
- Polarity and corner: ACT_LOW=1, PRESCALE=1, scan -> o=8'hFE, FD, FB … 7F on consecutive cycles; wrap every 8 cycles.
